// File: rtl/rgb_window_generator.sv
// Streaming 3x3 RGB window generator: two line buffers per channel, one window per
// accepted interior pixel, registered outputs held between windows.
module rgb_window_generator #(
    parameter int unsigned IMG_WIDTH  = 256,
    parameter int unsigned IMG_HEIGHT = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pixel_valid,
    input  logic       sof,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic       Enable,
    output logic [7:0] r1, r2, r3, r4, r5, r6, r7, r8, r9,
    output logic [7:0] g1, g2, g3, g4, g5, g6, g7, g8, g9,
    output logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          last_col, last_row;
    logic [7:0]    pix_in [3];
    logic [7:0]    lb0_q  [3][IMG_WIDTH];
    logic [7:0]    lb1_q  [3][IMG_WIDTH];
    logic [7:0]    win_q  [3][9];
    logic [7:0]    win_d  [3][9];
    logic [7:0]    out_q  [3][9];
    logic [7:0]    out_d  [3][9];
    logic          en_q, en_d, fd_q, fd_d;

    assign pix_in[0] = r_in;
    assign pix_in[1] = g_in;
    assign pix_in[2] = b_in;

    // sof restarts the frame at the pixel that carries it
    assign col_eff  = sof ? '0 : col_q;
    assign row_eff  = sof ? '0 : row_q;
    assign last_col = (col_eff == CW'(IMG_WIDTH - 1));
    assign last_row = (row_eff == RW'(IMG_HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        out_d = out_q;
        en_d  = 1'b0;
        fd_d  = 1'b0;
        if (pixel_valid) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 2; k++) begin
                    win_d[ch][k]     = win_q[ch][k+1];
                    win_d[ch][3 + k] = win_q[ch][4 + k];
                    win_d[ch][6 + k] = win_q[ch][7 + k];
                end
                win_d[ch][2] = lb1_q[ch][col_eff];
                win_d[ch][5] = lb0_q[ch][col_eff];
                win_d[ch][8] = pix_in[ch];
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
            // Gating on col >= 2 also discards columns left over from the previous row
            if ((row_eff >= RW'(2)) && (col_eff >= CW'(2))) begin
                out_d = win_d;
                en_d  = 1'b1;
                fd_d  = last_row && last_col;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            en_q  <= 1'b0;
            fd_q  <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 9; k++) begin
                    win_q[ch][k] <= '0;
                    out_q[ch][k] <= '0;
                end
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            en_q  <= en_d;
            fd_q  <= fd_d;
            win_q <= win_d;
            out_q <= out_d;
        end
    end

    // Line buffers are not cleared; the row gate masks stale contents
    always_ff @(posedge clock) begin
        if (pixel_valid && !reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                lb1_q[ch][col_eff] <= lb0_q[ch][col_eff];
                lb0_q[ch][col_eff] <= pix_in[ch];
            end
        end
    end

    assign Enable     = en_q;
    assign frame_done = fd_q;

    assign r1 = out_q[0][0];
    assign r2 = out_q[0][1];
    assign r3 = out_q[0][2];
    assign r4 = out_q[0][3];
    assign r5 = out_q[0][4];
    assign r6 = out_q[0][5];
    assign r7 = out_q[0][6];
    assign r8 = out_q[0][7];
    assign r9 = out_q[0][8];
    assign g1 = out_q[1][0];
    assign g2 = out_q[1][1];
    assign g3 = out_q[1][2];
    assign g4 = out_q[1][3];
    assign g5 = out_q[1][4];
    assign g6 = out_q[1][5];
    assign g7 = out_q[1][6];
    assign g8 = out_q[1][7];
    assign g9 = out_q[1][8];
    assign b1 = out_q[2][0];
    assign b2 = out_q[2][1];
    assign b3 = out_q[2][2];
    assign b4 = out_q[2][3];
    assign b5 = out_q[2][4];
    assign b6 = out_q[2][5];
    assign b7 = out_q[2][6];
    assign b8 = out_q[2][7];
    assign b9 = out_q[2][8];

endmodule

// File: tb/tb_rgb_window_generator.sv
// Scoreboard bench: an 8x6 instance exercised over full frames, gaps, sof abort and
// mid-frame reset, plus a 3x3 instance for the single-window case.
module tb_rgb_window_generator;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic [215:0] win;
        logic         fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, pixel_valid = 1'b0, sof = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic       en, fd;
    logic [7:0] ro [9];
    logic [7:0] go [9];
    logic [7:0] bo [9];

    logic       pv3 = 1'b0, sof3 = 1'b0;
    logic [7:0] r3_in = '0, g3_in = '0, b3_in = '0;
    logic       en3, fd3;
    logic [7:0] ro3 [9];
    logic [7:0] go3 [9];
    logic [7:0] bo3 [9];

    rgb_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
        .clock(clk), .reset(reset), .pixel_valid(pixel_valid), .sof(sof),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .Enable(en),
        .r1(ro[0]), .r2(ro[1]), .r3(ro[2]), .r4(ro[3]), .r5(ro[4]),
        .r6(ro[5]), .r7(ro[6]), .r8(ro[7]), .r9(ro[8]),
        .g1(go[0]), .g2(go[1]), .g3(go[2]), .g4(go[3]), .g5(go[4]),
        .g6(go[5]), .g7(go[6]), .g8(go[7]), .g9(go[8]),
        .b1(bo[0]), .b2(bo[1]), .b3(bo[2]), .b4(bo[3]), .b5(bo[4]),
        .b6(bo[5]), .b7(bo[6]), .b8(bo[7]), .b9(bo[8]),
        .frame_done(fd)
    );

    rgb_window_generator #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
        .clock(clk), .reset(reset), .pixel_valid(pv3), .sof(sof3),
        .r_in(r3_in), .g_in(g3_in), .b_in(b3_in), .Enable(en3),
        .r1(ro3[0]), .r2(ro3[1]), .r3(ro3[2]), .r4(ro3[3]), .r5(ro3[4]),
        .r6(ro3[5]), .r7(ro3[6]), .r8(ro3[7]), .r9(ro3[8]),
        .g1(go3[0]), .g2(go3[1]), .g3(go3[2]), .g4(go3[3]), .g5(go3[4]),
        .g6(go3[5]), .g7(go3[6]), .g8(go3[7]), .g9(go3[8]),
        .b1(bo3[0]), .b2(bo3[1]), .b3(bo3[2]), .b4(bo3[3]), .b5(bo3[4]),
        .b6(bo3[5]), .b7(bo3[6]), .b8(bo3[7]), .b9(bo3[8]),
        .frame_done(fd3)
    );

    int   n_checks = 0, n_pass = 0, n_fail = 0;
    int   n_win = 0, n_fd = 0, n_win3 = 0;
    int   mrow = 0, mcol = 0;
    logic acc_last = 1'b0;
    exp_t q[$];

    task automatic check(input string tag, input logic [216:0] obs, input logic [216:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pr(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    // Expected window whose bottom-right pixel is (row,col)
    function automatic logic [215:0] exp_win(input int row, input int col);
        logic [215:0] w;
        logic [7:0]   v;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                v = pr(row - 2 + dr, col - 2 + dc);
                w[(26 - (dr * 3 + dc)) * 8 +: 8] = v;
                w[(17 - (dr * 3 + dc)) * 8 +: 8] = v + 8'h80;
                w[(8 - (dr * 3 + dc)) * 8 +: 8]  = ~v;
            end
        end
        return w;
    endfunction

    function automatic logic [215:0] obs_win();
        logic [215:0] w;
        for (int k = 0; k < 9; k++) begin
            w[(26 - k) * 8 +: 8] = ro[k];
            w[(17 - k) * 8 +: 8] = go[k];
            w[(8 - k) * 8 +: 8]  = bo[k];
        end
        return w;
    endfunction

    function automatic logic [215:0] obs_win3();
        logic [215:0] w;
        for (int k = 0; k < 9; k++) begin
            w[(26 - k) * 8 +: 8] = ro3[k];
            w[(17 - k) * 8 +: 8] = go3[k];
            w[(8 - k) * 8 +: 8]  = bo3[k];
        end
        return w;
    endfunction

    always @(posedge clk) acc_last <= pixel_valid && !reset;

    always @(negedge clk) begin
        exp_t e;
        if (en) begin
            n_win++;
            check("enable_after_accept", 217'(acc_last), 217'(1));
            if (q.size() == 0) check("unexpected_window", 217'(1), 217'(0));
            else begin
                e = q.pop_front();
                check("window", {obs_win(), fd}, {e.win, e.fd});
            end
        end
        if (fd) begin
            n_fd++;
            check("frame_done_with_enable", 217'(en), 217'(1));
        end
        if (en3) n_win3++;
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input bit s, input bit gaps);
        exp_t e;
        if (gaps && $urandom_range(0, 99) < 40) idle();
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        r_in = pr(mrow, mcol);
        g_in = r_in + 8'h80;
        b_in = ~r_in;
        if (mrow >= 2 && mcol >= 2) begin
            e.win = exp_win(mrow, mcol);
            e.fd  = (mrow == H - 1) && (mcol == W - 1);
            q.push_back(e);
        end
        pixel_valid = 1'b1;
        sof = s;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        sof = 1'b0;
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic frame(input bit s_first, input bit gaps, input string tag);
        int bw, bf;
        bw = n_win;
        bf = n_fd;
        for (int i = 0; i < W * H; i++) pix(s_first && i == 0, gaps);
        idle();
        idle();
        check({tag, "_windows"}, 217'(n_win - bw), 217'((W - 2) * (H - 2)));
        check({tag, "_frame_done"}, 217'(n_fd - bf), 217'(1));
    endtask

    initial begin
        int bw, bf;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {obs_win(), en, fd}, '0);
        reset = 1'b0;

        frame(1'b1, 1'b0, "frame_a");
        frame(1'b0, 1'b0, "frame_b");
        frame(1'b0, 1'b1, "frame_gaps");

        // Abort at (3,4) with sof
        for (int i = 0; i < 3 * W + 4; i++) pix(1'b0, 1'b0);
        idle();
        bf = n_fd;
        frame(1'b1, 1'b0, "frame_sof");
        check("sof_abort_no_extra_done", 217'(n_fd - bf), 217'(1));

        // Reset with a pixel at (4,5): that pixel is dropped
        for (int i = 0; i < 4 * W + 5; i++) pix(1'b0, 1'b0);
        reset = 1'b1;
        pixel_valid = 1'b1;
        r_in = pr(4, 5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        check("mid_frame_reset", {obs_win(), en, fd}, '0);
        mrow = 0;
        mcol = 0;
        frame(1'b0, 1'b0, "frame_after_reset");
        check("scoreboard_empty", 217'(q.size()), 217'(0));

        bw = n_win3;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                r3_in = pr(r, c);
                g3_in = r3_in + 8'h80;
                b3_in = ~r3_in;
                pv3 = 1'b1;
                @(posedge clk);
                #1;
                pv3 = 1'b0;
            end
        end
        check("w3_window", {obs_win3(), en3, fd3}, {exp_win(2, 2), 1'b1, 1'b1});
        idle();
        idle();
        check("w3_window_count", 217'(n_win3 - bw), 217'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
